// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES-128 round sequencer:
//   - aes_state_e : sequencer FSM states
//   - AES_NR      : default round count
//   - RIDX_W      : round-index width
//   - RCON_INIT   : first round constant
//   - RCON_POLY   : GF(2^8) reduction term used by xtime
//   - xtime()     : multiply-by-x in GF(2^8)
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int          AES_NR    = 10;
  localparam int          RIDX_W    = 4;
  localparam logic [7:0]  RCON_INIT = 8'h01;
  localparam logic [7:0]  RCON_POLY = 8'h1B;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_HOLD  = 3'd4
  } aes_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// ---------------------------------------------------------------------------
// aes_rcon_gen
// Registered round-constant generator for the on-the-fly key expansion.
// Ports:
//   clk      in   clock
//   rst_n    in   async active-low reset (constant returns to 00)
//   load_i   in   load RCON_INIT
//   adv_i    in   advance constant by xtime
//   clr_i    in   force constant to 00
//   rcon_o   out  current round constant
// Priority: clear > load > advance.
// ---------------------------------------------------------------------------
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       adv_i,
  input  logic       clr_i,
  output logic [7:0] rcon_o
);

  logic [7:0] rcon_q;
  logic [7:0] rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (clr_i)       rcon_d = 8'h00;
    else if (load_i) rcon_d = RCON_INIT;
    else if (adv_i)  rcon_d = xtime(rcon_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rcon_q <= 8'h00;
    else        rcon_q <= rcon_d;
  end

  assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_round_sched.sv
// ---------------------------------------------------------------------------
// aes_round_sched
// Round sequencer for the iterative AES-128 encryption datapath. Steps the
// shared round logic through the initial AddRoundKey, NR-1 full rounds and
// the final round, and hands the result out over a valid/ready handshake.
// Ports:
//   clk        in   clock
//   rst_n      in   async active-low reset
//   start      in   request a new block (taken only when in_ready=1)
//   in_ready   out  sequencer idle
//   state_ld   out  state reg loads plaintext ^ key0
//   round_en   out  state/key regs capture round outputs
//   enbmc      out  MixColumns enable (0 = bypass)
//   round_idx  out  current round, 0..NR
//   rcon       out  round constant for round_idx
//   busy       out  INIT through FINAL
//   out_valid  out  ciphertext valid in state reg
//   out_ready  in   consumer takes result
// Parameter NR: total rounds, legal range 2..10.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start, in_ready=1
// ST_INIT  | initial AddRoundKey, state_ld=1, round_idx=0
// ST_ROUND | full round 1..NR-1, round_en=1, enbmc=1
// ST_FINAL | last round NR, round_en=1, MixColumns bypassed
// ST_HOLD  | result valid, wait for out_ready
// ---------------------------------------------------------------------------
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              in_ready,
  output logic              state_ld,
  output logic              round_en,
  output logic              enbmc,
  output logic [RIDX_W-1:0] round_idx,
  output logic [7:0]        rcon,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [RIDX_W-1:0] LAST_FULL = RIDX_W'(NR - 1);
  localparam logic [RIDX_W-1:0] FINAL_IDX = RIDX_W'(NR);

  aes_state_e        state_q;
  logic              state_ld_q;
  logic              round_en_q;
  logic              enbmc_q;
  logic              busy_q;
  logic              out_valid_q;
  logic [RIDX_W-1:0] round_idx_q;

  // Strobes are produced one edge ahead, together with the state they belong
  // to, so every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      state_ld_q  <= 1'b0;
      round_en_q  <= 1'b0;
      enbmc_q     <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      round_idx_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_INIT;
            state_ld_q  <= 1'b1;
            busy_q      <= 1'b1;
            round_idx_q <= '0;
          end
        end
        ST_INIT: begin
          state_q     <= ST_ROUND;
          state_ld_q  <= 1'b0;
          round_en_q  <= 1'b1;
          enbmc_q     <= 1'b1;
          round_idx_q <= RIDX_W'(1);
        end
        ST_ROUND: begin
          if (round_idx_q == LAST_FULL) begin
            state_q     <= ST_FINAL;
            enbmc_q     <= 1'b0;
            round_idx_q <= FINAL_IDX;
          end else begin
            round_idx_q <= round_idx_q + RIDX_W'(1);
          end
        end
        ST_FINAL: begin
          state_q     <= ST_HOLD;
          round_en_q  <= 1'b0;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
          round_idx_q <= '0;
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          state_ld_q  <= 1'b0;
          round_en_q  <= 1'b0;
          enbmc_q     <= 1'b0;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          round_idx_q <= '0;
        end
      endcase
    end
  end

  // The constant is loaded as INIT hands over to round 1, steps once per
  // full round, and is cleared as FINAL ends so HOLD/IDLE read 00.
  logic rcon_load;
  logic rcon_adv;
  logic rcon_clr;

  assign rcon_load = (state_q == ST_INIT);
  assign rcon_adv  = (state_q == ST_ROUND);
  assign rcon_clr  = (state_q == ST_IDLE) || (state_q == ST_FINAL) ||
                     (state_q == ST_HOLD);

  aes_rcon_gen u_rcon_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (rcon_load),
    .adv_i  (rcon_adv),
    .clr_i  (rcon_clr),
    .rcon_o (rcon)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign state_ld  = state_ld_q;
  assign round_en  = round_en_q;
  assign enbmc     = enbmc_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign round_idx = round_idx_q;

endmodule

// File: tb/tb_aes_round_sched.sv
module tb_aes_round_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic       start = 1'b0, out_ready = 1'b0;
  logic       in_ready, state_ld, round_en, enbmc, busy, out_valid;
  logic [3:0] round_idx;
  logic [7:0] rcon;

  logic       start2 = 1'b0, out_ready2 = 1'b1;
  logic       in_ready2, state_ld2, round_en2, enbmc2, busy2, out_valid2;
  logic [3:0] round_idx2;
  logic [7:0] rcon2;

  aes_round_sched #(.NR(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_ready(in_ready),
    .state_ld(state_ld), .round_en(round_en), .enbmc(enbmc),
    .round_idx(round_idx), .rcon(rcon), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready));

  aes_round_sched #(.NR(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_ready(in_ready2),
    .state_ld(state_ld2), .round_en(round_en2), .enbmc(enbmc2),
    .round_idx(round_idx2), .rcon(rcon2), .busy(busy2),
    .out_valid(out_valid2), .out_ready(out_ready2));

  typedef struct {
    logic [3:0] idx;
    logic [7:0] rc;
    logic       mc;
  } rnd_t;

  typedef struct {
    logic       start;
    logic       ordy;
    logic       sld;
    logic       ren;
    logic       mc;
    logic       ov;
    logic       bsy;
    logic       ir;
    logic [3:0] idx;
  } vec_t;

  rnd_t rnd_tbl[10];
  vec_t trace[14];
  rnd_t sb_q[$];
  int   rise_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic prev_ov = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_state_ld"},  state_ld,  0);
    check({tag, "_round_en"},  round_en,  0);
    check({tag, "_enbmc"},     enbmc,     0);
    check({tag, "_round_idx"}, round_idx, 0);
    check({tag, "_rcon"},      rcon,      0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_out_valid"}, out_valid, 0);
  endtask

  // bounded wait for out_valid on the NR=10 instance; n = cycles after acceptance
  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < maxc);
    if (!out_valid) check("wait_out_valid_timeout", 0, 1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: acceptance pushes the ten expected rounds, each round_en pops one
  always @(negedge clk) begin
    rnd_t e;
    if (rst_n) begin
      if (in_ready && start)
        for (int k = 0; k < 10; k++) sb_q.push_back(rnd_tbl[k]);
      if (state_ld || round_en) check("exclusive_ld_en", {31'd0, state_ld & round_en}, 0);
      if (round_en) begin
        if (sb_q.size() == 0) check("unexpected_round", 1, 0);
        else begin
          e = sb_q.pop_front();
          check("sb_round_idx", round_idx, e.idx);
          check("sb_rcon", rcon, e.rc);
          check("sb_enbmc", enbmc, e.mc);
        end
      end
      if (out_valid && !prev_ov) rise_q.push_back(cyc);
      prev_ov <= out_valid;
    end else begin
      prev_ov <= 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rc_ref [10];
    int   n;
    logic seen;

    rc_ref = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    for (int k = 0; k < 10; k++) begin
      rnd_tbl[k].idx = 4'(k + 1);
      rnd_tbl[k].rc  = rc_ref[k];
      rnd_tbl[k].mc  = (k < 9);
    end
    trace[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
    trace[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
    for (int c = 2; c <= 10; c++)
      trace[c] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'(c - 1)};
    trace[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd10};
    trace[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    trace[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};

    // reset values
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    check("rst_in_ready2", in_ready2, 1);
    check("rst_out_valid2", out_valid2, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single block, cycle-by-cycle trace
    for (int c = 0; c < 14; c++) begin
      start     = trace[c].start;
      out_ready = trace[c].ordy;
      @(negedge clk);
      check($sformatf("tr%0d_state_ld", c),  state_ld,  trace[c].sld);
      check($sformatf("tr%0d_round_en", c),  round_en,  trace[c].ren);
      check($sformatf("tr%0d_enbmc", c),     enbmc,     trace[c].mc);
      check($sformatf("tr%0d_out_valid", c), out_valid, trace[c].ov);
      check($sformatf("tr%0d_busy", c),      busy,      trace[c].bsy);
      check($sformatf("tr%0d_in_ready", c),  in_ready,  trace[c].ir);
      check($sformatf("tr%0d_round_idx", c), round_idx, trace[c].idx);
      @(posedge clk);
      #1;
    end
    check("single_sb_drained", sb_q.size(), 0);

    // backpressure in HOLD, start pulses ignored
    out_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_valid(20, n);
    check("bp_latency", n, 12);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1 start = k[0];
      @(negedge clk);
      check("bp_out_valid_held", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
    end
    @(posedge clk); #1 start = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", out_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle_in_ready", in_ready, 1);
    check("bp_idle_out_valid", out_valid, 0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | busy | state_ld;
    end
    check("bp_no_second_block", seen, 0);
    check("bp_sb_drained", sb_q.size(), 0);

    // back-to-back with start and out_ready held high
    @(posedge clk); #1;
    rise_q.delete();
    start = 1'b1; out_ready = 1'b1;
    n = 0;
    while (rise_q.size() < 4 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("b2b_rises_seen", rise_q.size() >= 4, 1);
    if (rise_q.size() >= 4)
      for (int k = 1; k < 4; k++)
        check($sformatf("b2b_period%0d", k), rise_q[k] - rise_q[k-1], 13);
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(negedge clk);
    check("b2b_idle", in_ready, 1);
    check("b2b_sb_drained", sb_q.size(), 0);

    // reset in the middle of round 5
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(round_en && round_idx == 4'd5) && n < 20);
    check("mid_reached_round5", round_idx, 5);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen = seen | out_valid | busy;
    end
    check("midrst_no_stale_result", seen, 0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_valid(20, n);
    check("midrst_fresh_latency", n, 12);
    repeat (3) @(negedge clk);
    check("midrst_sb_drained", sb_q.size(), 0);
    check("midrst_back_idle", in_ready, 1);

    // NR=2 instance
    @(posedge clk); #1 start2 = 1'b1; out_ready2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    @(negedge clk);
    check("nr2_c1_state_ld", state_ld2, 1);
    check("nr2_c1_round_en", round_en2, 0);
    check("nr2_c1_rcon", rcon2, 8'h00);
    @(negedge clk);
    check("nr2_c2_round_en", round_en2, 1);
    check("nr2_c2_enbmc", enbmc2, 1);
    check("nr2_c2_round_idx", round_idx2, 1);
    check("nr2_c2_rcon", rcon2, 8'h01);
    @(negedge clk);
    check("nr2_c3_round_en", round_en2, 1);
    check("nr2_c3_enbmc", enbmc2, 0);
    check("nr2_c3_round_idx", round_idx2, 2);
    check("nr2_c3_rcon", rcon2, 8'h02);
    @(negedge clk);
    check("nr2_c4_out_valid", out_valid2, 1);
    check("nr2_c4_round_en", round_en2, 0);
    check("nr2_c4_rcon", rcon2, 8'h00);
    @(negedge clk);
    check("nr2_c5_in_ready", in_ready2, 1);
    check("nr2_c5_out_valid", out_valid2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
